// File: rtl/branch_predict_unit_if.sv
// Bus bundle between the pipeline and the branch predict unit.
// Lookup side: the IF PC mux presents IF_PC/IF_PC_IMM/IF_isBranch and gets a
// combinational prediction and redirect PC back in the same cycle.
// Resolve side: the EX stage presents one instruction per cycle.
// Handshake semantics: EX_valid qualifies every EX_* field in the cycle it is
// high. There is no backpressure, so the unit consumes a qualified EX slot on
// the clock edge that ends the cycle. The ready output does not gate EX
// traffic: it only says the BHT has been cleared and lookups may predict taken.
// flush/newPC/update/correct are pulses or values that are valid for exactly
// the cycle after the resolving edge.
interface branch_predict_unit_if #(
  parameter int DBITS       = 32,
  parameter int OPCODE_BITS = 4,
  parameter int STAT_BITS   = 16
);
  // Fetch-side lookup
  logic [DBITS-1:0]       IF_PC;
  logic [DBITS-1:0]       IF_PC_IMM;
  logic                   IF_isBranch;
  logic                   IF_prediction;
  logic [DBITS-1:0]       IF_predPC;

  // Execute-side resolution
  logic                   EX_valid;
  logic [OPCODE_BITS-1:0] EX_opcode;
  logic [DBITS-1:0]       EX_PC;
  logic [DBITS-1:0]       EX_PC_IMM;
  logic                   EX_condFlag;
  logic                   EX_prediction;

  // Registered resolve results and status
  logic                   flush;
  logic [DBITS-1:0]       newPC;
  logic                   update;
  logic                   correct;
  logic                   ready;
  logic [STAT_BITS-1:0]   branchCount;
  logic [STAT_BITS-1:0]   mispredCount;

  // Pipeline side: drives fetch/execute information, consumes results
  modport master (
    output IF_PC, IF_PC_IMM, IF_isBranch,
    output EX_valid, EX_opcode, EX_PC, EX_PC_IMM, EX_condFlag, EX_prediction,
    input  IF_prediction, IF_predPC,
    input  flush, newPC, update, correct, ready, branchCount, mispredCount
  );

  // Predictor side
  modport slave (
    input  IF_PC, IF_PC_IMM, IF_isBranch,
    input  EX_valid, EX_opcode, EX_PC, EX_PC_IMM, EX_condFlag, EX_prediction,
    output IF_prediction, IF_predPC,
    output flush, newPC, update, correct, ready, branchCount, mispredCount
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch predict unit: PC-indexed table of 2-bit saturating counters feeding
// the IF-stage prediction, trained by the EX-stage resolver. Resolution
// produces a registered flush/newPC/update/correct, squashes the wrong-path
// slot that follows a flush, and keeps saturating branch/mispredict counts.
// A clear FSM walks the whole table after reset before lookups may predict.
module branch_predict_unit #(
  parameter int                     DBITS          = 32,
  parameter int                     OPCODE_BITS    = 4,
  parameter logic [OPCODE_BITS-1:0] BRANCH_OPCODE  = 4'b0010,
  parameter int                     BHT_INDEX_BITS = 6,
  parameter logic [1:0]             CTR_INIT       = 2'b01,
  parameter int                     STAT_BITS      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  branch_predict_unit_if.slave      bus,
  // Debug visibility of the clear FSM: 1 = RUN, 0 = INIT
  output logic                      state_dbg,
  output logic [BHT_INDEX_BITS-1:0] clr_idx_dbg
);

  localparam int ENTRIES = 1 << BHT_INDEX_BITS;
  localparam logic [BHT_INDEX_BITS-1:0] LAST_IDX = BHT_INDEX_BITS'(ENTRIES - 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                    state;
  logic [BHT_INDEX_BITS-1:0] clr_idx;
  logic                      squash;
  logic [1:0]                bht [ENTRIES];

  logic [BHT_INDEX_BITS-1:0] if_idx;
  logic [BHT_INDEX_BITS-1:0] ex_idx;
  logic                      if_taken;
  logic                      resolve;
  logic                      mispred;
  logic [1:0]                ex_ctr;
  logic [1:0]                ex_ctr_next;
  logic [DBITS-1:0]          redirect_pc;

  // Word-aligned PCs: drop the two byte-offset bits before indexing
  assign if_idx = bus.IF_PC[BHT_INDEX_BITS+1:2];
  assign ex_idx = bus.EX_PC[BHT_INDEX_BITS+1:2];

  assign state_dbg   = (state == RUN);
  assign clr_idx_dbg = clr_idx;

  // Fetch-side lookup: reads the pre-edge table, no bypass from EX training
  always_comb begin
    if_taken          = bht[if_idx][1];
    bus.IF_prediction = bus.ready & bus.IF_isBranch & if_taken;
    bus.IF_predPC     = bus.IF_prediction ? bus.IF_PC_IMM : bus.IF_PC + DBITS'(4);
  end

  // Resolve decode, counter training value and redirect target
  always_comb begin
    resolve     = bus.EX_valid && (bus.EX_opcode == BRANCH_OPCODE) && !squash;
    mispred     = resolve && (bus.EX_condFlag != bus.EX_prediction);
    ex_ctr      = bht[ex_idx];
    ex_ctr_next = ex_ctr;
    if (bus.EX_condFlag) begin
      if (ex_ctr != 2'b11) ex_ctr_next = ex_ctr + 2'b01;
    end else begin
      if (ex_ctr != 2'b00) ex_ctr_next = ex_ctr - 2'b01;
    end
    // Actually taken means we predicted not-taken: go to the target.
    // Actually not-taken means we predicted taken: go to the fall-through.
    redirect_pc = bus.EX_condFlag ? bus.EX_PC_IMM : bus.EX_PC + DBITS'(4);
  end

  // Clear FSM: INIT walks every entry once, RUN holds until the next reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      clr_idx   <= '0;
      bus.ready <= 1'b0;
    end else begin
      // ready trails the state by one edge so the last clear write is visible
      bus.ready <= (state == RUN);
      case (state)
        INIT: begin
          clr_idx <= clr_idx + BHT_INDEX_BITS'(1);
          if (clr_idx == LAST_IDX) state <= RUN;
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  // Table write port: the clear write wins over training while in INIT
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        bht[clr_idx] <= CTR_INIT;
      end else if (resolve) begin
        bht[ex_idx] <= ex_ctr_next;
      end
    end
  end

  // Resolve results and wrong-path squash
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.flush   <= 1'b0;
      bus.newPC   <= '0;
      bus.update  <= 1'b0;
      bus.correct <= 1'b0;
      squash      <= 1'b0;
    end else begin
      bus.update <= resolve;
      bus.flush  <= mispred;
      squash     <= mispred;
      if (resolve) bus.correct <= !mispred;
      if (mispred) bus.newPC   <= redirect_pc;
    end
  end

  // Saturating statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.branchCount  <= '0;
      bus.mispredCount <= '0;
    end else begin
      if (resolve && (bus.branchCount != '1)) begin
        bus.branchCount <= bus.branchCount + STAT_BITS'(1);
      end
      if (mispred && (bus.mispredCount != '1)) begin
        bus.mispredCount <= bus.mispredCount + STAT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Testbench for branch_predict_unit. Two instances share one stimulus stream:
// the default 16-bit statistics build and a 4-bit build whose counters reach
// saturation within the run.
module tb_branch_predict_unit;

  localparam int         DBITS   = 32;
  localparam logic [3:0] BR_OP   = 4'b0010;
  localparam int         ENTRIES = 64;
  localparam int         W       = 75;

  logic clk = 1'b0;
  logic reset;
  logic state_dbg, state_dbg4;
  logic [5:0] clr_idx_dbg, clr_idx_dbg4;

  branch_predict_unit_if #(.DBITS(32), .OPCODE_BITS(4), .STAT_BITS(16)) bus ();
  branch_predict_unit_if #(.DBITS(32), .OPCODE_BITS(4), .STAT_BITS(4))  bus4 ();

  branch_predict_unit #(.STAT_BITS(16)) u_dut (
    .clk(clk), .reset(reset), .bus(bus),
    .state_dbg(state_dbg), .clr_idx_dbg(clr_idx_dbg)
  );

  branch_predict_unit #(.STAT_BITS(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4),
    .state_dbg(state_dbg4), .clr_idx_dbg(clr_idx_dbg4)
  );

  assign bus4.IF_PC         = bus.IF_PC;
  assign bus4.IF_PC_IMM     = bus.IF_PC_IMM;
  assign bus4.IF_isBranch   = bus.IF_isBranch;
  assign bus4.EX_valid      = bus.EX_valid;
  assign bus4.EX_opcode     = bus.EX_opcode;
  assign bus4.EX_PC         = bus.EX_PC;
  assign bus4.EX_PC_IMM     = bus.EX_PC_IMM;
  assign bus4.EX_condFlag   = bus.EX_condFlag;
  assign bus4.EX_prediction = bus.EX_prediction;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  logic [1:0]  m_bht [ENTRIES];
  logic        m_squash, m_flush, m_update, m_correct, m_ready;
  logic [31:0] m_newpc;
  logic [15:0] m_bc, m_mc;
  logic [3:0]  m_bc4, m_mc4;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_bht[i] = 2'b01;
    m_squash = 1'b0; m_flush = 1'b0; m_update = 1'b0; m_correct = 1'b0;
    m_ready = 1'b0; m_newpc = '0;
    m_bc = '0; m_mc = '0; m_bc4 = '0; m_mc4 = '0;
  endtask

  // ---------------- driver tasks ----------------
  // Drive one EX slot, push the expected outcome, step one edge, compare.
  task automatic ex_cycle(input logic v, input logic [3:0] op, input logic [31:0] pc,
                          input logic [31:0] imm, input logic cond, input logic pred);
    logic res, mis;
    logic [5:0] idx;
    logic [W-1:0] e;
    bus.EX_valid = v; bus.EX_opcode = op; bus.EX_PC = pc;
    bus.EX_PC_IMM = imm; bus.EX_condFlag = cond; bus.EX_prediction = pred;
    res = v && (op == BR_OP) && !m_squash;
    mis = res && (cond != pred);
    idx = pc[7:2];
    if (res) begin
      if (m_bc  != 16'hFFFF) m_bc  = m_bc + 1;
      if (m_bc4 != 4'hF)     m_bc4 = m_bc4 + 1;
      if (cond && m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 1;
      if (!cond && m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 1;
      m_correct = !mis;
    end
    if (mis) begin
      if (m_mc  != 16'hFFFF) m_mc  = m_mc + 1;
      if (m_mc4 != 4'hF)     m_mc4 = m_mc4 + 1;
      m_newpc = cond ? imm : pc + 32'd4;
    end
    m_update = res; m_flush = mis; m_squash = mis;
    exp_q.push_back({m_flush, m_update, m_correct, m_newpc, m_bc, m_mc, m_bc4, m_mc4});
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("flush",    64'(bus.flush),         64'(e[74]));
      check("update",   64'(bus.update),        64'(e[73]));
      check("correct",  64'(bus.correct),       64'(e[72]));
      check("newPC",    64'(bus.newPC),         64'(e[71:40]));
      check("brCount",  64'(bus.branchCount),   64'(e[39:24]));
      check("mpCount",  64'(bus.mispredCount),  64'(e[23:8]));
      check("brCount4", 64'(bus4.branchCount),  64'(e[7:4]));
      check("mpCount4", 64'(bus4.mispredCount), 64'(e[3:0]));
    end
  endtask

  task automatic idle_cycle();
    ex_cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Combinational lookup against the model table
  task automatic look(input string tag, input logic [31:0] pc, input logic [31:0] imm);
    logic ep;
    bus.IF_PC = pc; bus.IF_PC_IMM = imm; bus.IF_isBranch = 1'b1;
    #1;
    ep = m_ready & m_bht[pc[7:2]][1];
    check({tag, "_pred"},   64'(bus.IF_prediction), 64'(ep));
    check({tag, "_predPC"}, 64'(bus.IF_predPC),     64'(ep ? imm : pc + 32'd4));
  endtask

  // Called #1 after the edge that sampled reset high: watch the full clear
  task automatic run_init();
    check("rst_ready",   64'(bus.ready),       64'd0);
    check("rst_clr_idx", 64'(clr_idx_dbg),     64'd0);
    check("rst_state",   64'(state_dbg),       64'd0);
    reset = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk); #1;
      check("init_ready",   64'(bus.ready),   64'd0);
      check("init_clr_idx", 64'(clr_idx_dbg), 64'(c % 64));
    end
    check("init_state_run", 64'(state_dbg), 64'd1);
    @(posedge clk); #1;
    check("ready_rise",  64'(bus.ready),  64'd1);
    check("ready_rise4", 64'(bus4.ready), 64'd1);
    m_ready = 1'b1;
    for (int i = 0; i < ENTRIES; i++) begin
      look("init_entry", 32'(i * 4), 32'h8000_0000);
      @(posedge clk); #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic cond, pred, v;
    logic [3:0] op;
    logic [31:0] pc;
    int guard;

    reset = 1'b1;
    bus.IF_PC = '0; bus.IF_PC_IMM = '0; bus.IF_isBranch = 1'b0;
    bus.EX_valid = 1'b0; bus.EX_opcode = '0; bus.EX_PC = '0;
    bus.EX_PC_IMM = '0; bus.EX_condFlag = 1'b0; bus.EX_prediction = 1'b0;
    model_reset();

    @(posedge clk); #1;
    check("rst_flush",   64'(bus.flush),        64'd0);
    check("rst_newPC",   64'(bus.newPC),        64'd0);
    check("rst_update",  64'(bus.update),       64'd0);
    check("rst_correct", 64'(bus.correct),      64'd0);
    check("rst_brCount", 64'(bus.branchCount),  64'd0);
    check("rst_mpCount", 64'(bus.mispredCount), 64'd0);
    run_init();

    // Mispredicted taken branch at 0x100 -> redirect to target, counter 2
    ex_cycle(1'b1, BR_OP, 32'h100, 32'h140, 1'b1, 1'b0);
    check("t2_flush",  64'(bus.flush), 64'd1);
    check("t2_newPC",  64'(bus.newPC), 64'h140);
    check("t2_mp",     64'(bus.mispredCount), 64'd1);
    look("t2_lookup", 32'h100, 32'h140);
    check("t2_taken",  64'(bus.IF_prediction), 64'd1);

    // Wrong-path slot right after the flush must be ignored
    ex_cycle(1'b1, BR_OP, 32'h200, 32'h240, 1'b1, 1'b0);
    check("sq_flush",  64'(bus.flush),       64'd0);
    check("sq_update", 64'(bus.update),      64'd0);
    check("sq_br",     64'(bus.branchCount), 64'd1);

    // Four correct taken resolves back to back saturate the counter at 3
    for (int i = 0; i < 4; i++) ex_cycle(1'b1, BR_OP, 32'h100, 32'h140, 1'b1, 1'b1);
    check("sat_br", 64'(bus.branchCount), 64'd5);
    ex_cycle(1'b1, BR_OP, 32'h100, 32'h140, 1'b0, 1'b1);
    check("nt_flush", 64'(bus.flush), 64'd1);
    check("nt_newPC", 64'(bus.newPC), 64'h104);
    look("nt_lookup", 32'h100, 32'h140);
    check("nt_still_taken", 64'(bus.IF_prediction), 64'd1);
    idle_cycle();

    // Non-branch opcode and invalid slot do not resolve
    ex_cycle(1'b1, 4'h3, 32'h180, 32'h1c0, 1'b1, 1'b0);
    ex_cycle(1'b0, BR_OP, 32'h180, 32'h1c0, 1'b1, 1'b0);

    // Random mix of resolves, squashes and lookups
    for (int i = 0; i < 40; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      op   = ($urandom_range(0, 4) == 0) ? 4'h7 : BR_OP;
      pc   = 32'($urandom_range(0, 255)) << 2;
      cond = 1'($urandom_range(0, 1));
      pred = 1'($urandom_range(0, 1));
      ex_cycle(v, op, pc, pc + 32'h40, cond, pred);
      look("rnd_lookup", 32'($urandom_range(0, 255)) << 2, 32'h4000);
    end

    // Twenty mispredictions, each followed by its squash slot
    for (int i = 0; i < 20; i++) begin
      pc   = 32'($urandom_range(0, 63)) << 2;
      cond = 1'($urandom_range(0, 1));
      ex_cycle(1'b1, BR_OP, pc, pc + 32'h80, cond, !cond);
      idle_cycle();
    end
    check("mp4_saturated", 64'(bus4.mispredCount), 64'hF);
    check("br4_saturated", 64'(bus4.branchCount),  64'hF);

    // PC wrap-around on the fall-through redirect
    ex_cycle(1'b1, BR_OP, 32'hFFFF_FFFC, 32'h10, 1'b0, 1'b1);
    check("wrap_newPC", 64'(bus.newPC), 64'h0);
    idle_cycle();

    // Reset in the middle of the clear restarts it from index 0
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    guard = 0;
    while (clr_idx_dbg != 6'd20 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("reach_idx20", 64'(clr_idx_dbg), 64'd20);
    reset = 1'b1;
    @(posedge clk); #1;
    run_init();
    check("post_rst_br", 64'(bus.branchCount), 64'd0);
    ex_cycle(1'b1, BR_OP, 32'h40, 32'h20, 1'b1, 1'b0);
    idle_cycle();
    ex_cycle(1'b1, BR_OP, 32'h40, 32'h20, 1'b1, 1'b1);

    if (exp_q.size() != 0) check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
